// File: rtl/ir_nec_receiver.sv
// ir_nec_receiver: decodes NEC IR frames into address/command with valid, error and repeat strobes.
// Defining IR_REPEAT_EN adds repeat-code decoding on the rpt strobe.
module ir_nec_receiver #(
  parameter int CLK_FREQ   = 50000000,
  parameter int TICK_US    = 10,
  parameter int TOUT_TICKS = 1100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ir_in,
  output logic [7:0] addr,
  output logic [7:0] cmd,
  output logic       data_valid,
  output logic       frame_err,
  output logic       rpt
);
  localparam int DIV = CLK_FREQ / 1000000 * TICK_US;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] P_TC = PW'(DIV - 1);
  localparam logic [10:0] TOUT   = 11'(TOUT_TICKS);
  localparam logic [10:0] LL_MIN = 11'd800, LL_MAX = 11'd1000;
  localparam logic [10:0] LH_MIN = 11'd400, LH_MAX = 11'd500;
  localparam logic [10:0] B_MIN  = 11'd40,  B_MAX  = 11'd70;
  localparam logic [10:0] B1_MIN = 11'd140, B1_MAX = 11'd190;
`ifdef IR_REPEAT_EN
  localparam logic [10:0] RH_MIN = 11'd200, RH_MAX = 11'd250;
`endif

  typedef enum logic [2:0] {IDLE, LEAD_L, LEAD_H, BIT_L, BIT_H, CHECK, ERR, RPT} state_t;

  function automatic logic in_win(input logic [10:0] v, input logic [10:0] lo, input logic [10:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  state_t      r_state;
  logic        r_s1, r_s2, r_prev, r_pend;
  logic [PW-1:0] r_pre;
  logic [10:0] r_w;
  logic [4:0]  r_idx;
  logic [31:0] r_sr;
  logic [7:0]  r_addr, r_cmd;
  logic        r_dv, r_fe;
  logic        w_tick, w_edge, w_fall, w_rise, w_tout, w_b, w_b1, w_ok;

  assign w_tick = (r_pre == P_TC);
  assign w_edge = r_prev ^ r_s2;
  assign w_fall = r_prev & ~r_s2;
  assign w_rise = ~r_prev & r_s2;
  assign w_tout = (r_w >= TOUT);
  assign w_b    = in_win(r_w, B_MIN, B_MAX);
  assign w_b1   = in_win(r_w, B1_MIN, B1_MAX);
  assign w_ok   = ((r_sr[7:0] ^ r_sr[15:8]) == 8'hFF) && ((r_sr[23:16] ^ r_sr[31:24]) == 8'hFF);

  // An edge sees the pre-increment width because the clear and the compare share a cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_prev <= 1'b1;
      r_pre  <= '0;
      r_w    <= '0;
    end else begin
      r_s1   <= ir_in;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      r_pre  <= w_tick ? '0 : r_pre + PW'(1);
      if (w_edge) r_w <= '0;
      else if (w_tick && r_w != 11'h7FF) r_w <= r_w + 11'd1;
    end

`ifdef IR_REPEAT_EN
  logic r_rpt, r_good;
  assign rpt = r_rpt;
`else
  assign rpt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_pend  <= 1'b0;
      r_idx   <= '0;
      r_sr    <= '0;
      r_addr  <= '0;
      r_cmd   <= '0;
      r_dv    <= 1'b0;
      r_fe    <= 1'b0;
`ifdef IR_REPEAT_EN
      r_rpt   <= 1'b0;
      r_good  <= 1'b0;
`endif
    end else begin
      r_dv   <= 1'b0;
      r_fe   <= 1'b0;
      r_pend <= 1'b0;
`ifdef IR_REPEAT_EN
      r_rpt  <= 1'b0;
`endif
      case (r_state)
        IDLE:   if (w_fall || r_pend) r_state <= LEAD_L;
        LEAD_L: if (w_rise) r_state <= in_win(r_w, LL_MIN, LL_MAX) ? LEAD_H : IDLE;
                else if (w_tout) r_state <= IDLE;
        LEAD_H: if (w_fall) begin
                  if (in_win(r_w, LH_MIN, LH_MAX)) begin
                    r_idx   <= '0;
                    r_state <= BIT_L;
                  end
`ifdef IR_REPEAT_EN
                  else if (in_win(r_w, RH_MIN, RH_MAX)) r_state <= RPT;
`endif
                  else r_state <= IDLE;
                end else if (w_tout) r_state <= IDLE;
        BIT_L:  if (w_rise) r_state <= w_b ? BIT_H : ERR;
                else if (w_tout) r_state <= ERR;
        BIT_H:  if (w_fall) begin
                  if (w_b || w_b1) begin
                    r_sr    <= {w_b1, r_sr[31:1]};
                    r_idx   <= r_idx + 5'd1;
                    r_state <= (r_idx == 5'd31) ? CHECK : BIT_L;
                  end else r_state <= ERR;
                end else if (w_tout) r_state <= ERR;
        CHECK:  begin
                  if (w_ok) begin
                    r_addr <= r_sr[7:0];
                    r_cmd  <= r_sr[23:16];
                    r_dv   <= 1'b1;
`ifdef IR_REPEAT_EN
                    r_good <= 1'b1;
`endif
                  end else r_fe <= 1'b1;
                  r_pend  <= w_fall;
                  r_state <= IDLE;
                end
        ERR:    begin
                  r_fe    <= 1'b1;
                  r_pend  <= w_fall;
                  r_state <= IDLE;
                end
`ifdef IR_REPEAT_EN
        RPT:    if (w_rise) begin
                  if (w_b) r_rpt <= r_good;
                  else r_fe <= 1'b1;
                  r_state <= IDLE;
                end else if (w_tout) r_state <= ERR;
`endif
        default: r_state <= IDLE;
      endcase
    end

  assign addr       = r_addr;
  assign cmd        = r_cmd;
  assign data_valid = r_dv;
  assign frame_err  = r_fe;
endmodule

// File: tb/tb_ir_nec_receiver.sv
// tb_ir_nec_receiver: scoreboard bench for the NEC receiver, one tick per clock to keep frames short.
`timescale 1ns/1ps
module tb_ir_nec_receiver;
  logic       clk = 1'b0, rst_n = 1'b0, ir_in = 1'b1;
  logic [7:0] addr, cmd;
  logic       data_valid, frame_err, rpt;

  typedef struct packed {logic [2:0] kind; logic [7:0] a; logic [7:0] c;} exp_t;
  exp_t q[$];
  exp_t e_mon;
  int   n_chk = 0, n_fail = 0;
  logic [7:0] m_addr = 8'h00, m_cmd = 8'h00;

  ir_nec_receiver #(.CLK_FREQ(1000000), .TICK_US(1), .TOUT_TICKS(1100)) dut (
    .clk(clk), .rst_n(rst_n), .ir_in(ir_in), .addr(addr), .cmd(cmd),
    .data_valid(data_valid), .frame_err(frame_err), .rpt(rpt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic lvl(input logic v, input int n);
    ir_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input int ll, input int lh);
    logic [31:0] w;
    logic ok;
    int k;
    w  = {b3, b2, b1, b0};
    ok = ((b0 ^ b1) == 8'hFF) && ((b2 ^ b3) == 8'hFF);
    if (ok) begin
      q.push_back(exp_t'{kind: 3'b100, a: b0, c: b2});
      m_addr = b0;
      m_cmd  = b2;
    end else q.push_back(exp_t'{kind: 3'b010, a: 8'h00, c: 8'h00});
    lvl(1'b0, ll);
    lvl(1'b1, lh);
    for (int i = 0; i < 32; i++) begin
      lvl(1'b0, 56);
      lvl(1'b1, w[i] ? 169 : 56);
    end
    ir_in = 1'b0;
    k = 0;
    while (k < 10 && !(data_valid || frame_err)) begin
      @(negedge clk);
      k++;
    end
    chk("strobe_latency", k, 4);
    repeat (56 - k) @(negedge clk);
    lvl(1'b1, 200);
  endtask

  task automatic send_repeat();
    lvl(1'b0, 900);
    lvl(1'b1, 225);
    lvl(1'b0, 56);
    lvl(1'b1, 300);
  endtask

  always @(negedge clk)
    if (data_valid || frame_err || rpt) begin
      chk("one_hot", 32'(data_valid) + 32'(frame_err) + 32'(rpt), 1);
      if (q.size() == 0) chk("unexpected_strobe", {data_valid, frame_err, rpt}, 0);
      else begin
        e_mon = q.pop_front();
        chk("strobe_kind", {data_valid, frame_err, rpt}, e_mon.kind);
        if (e_mon.kind == 3'b100) begin
          chk("addr", addr, e_mon.a);
          chk("cmd", cmd, e_mon.c);
        end
      end
    end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_addr", addr, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_strobes", {data_valid, frame_err, rpt}, 0);
    rst_n = 1'b1;
    lvl(1'b1, 50);
    send_frame(8'h00, 8'hFF, 8'h45, 8'hBA, 900, 450);
    send_frame(8'h00, 8'hFF, 8'h45, 8'hBB, 900, 450);
    chk("hold_addr", addr, m_addr);
    chk("hold_cmd", cmd, m_cmd);
    lvl(1'b0, 500);
    lvl(1'b1, 300);
    send_frame(8'h5A, 8'hA5, 8'h16, 8'hE9, 900, 450);
    q.push_back(exp_t'{kind: 3'b010, a: 8'h00, c: 8'h00});
    lvl(1'b0, 900);
    lvl(1'b1, 450);
    for (int i = 0; i < 12; i++) begin
      lvl(1'b0, 56);
      lvl(1'b1, 56);
    end
    lvl(1'b0, 56);
    lvl(1'b1, 1500);
    send_frame(8'h10, 8'hEF, 8'h22, 8'hDD, 900, 450);
    send_frame(8'hA5, 8'h5A, 8'h3C, 8'hC3, 801, 401);
    lvl(1'b0, 1002);
    lvl(1'b1, 400);
    q.push_back(exp_t'{kind: 3'b010, a: 8'h00, c: 8'h00});
    lvl(1'b0, 900);
    lvl(1'b1, 450);
    lvl(1'b0, 56);
    lvl(1'b1, 100);
    lvl(1'b0, 56);
    lvl(1'b1, 300);
    send_frame(8'h00, 8'hFF, 8'h18, 8'hE7, 900, 450);
`ifdef IR_REPEAT_EN
    q.push_back(exp_t'{kind: 3'b001, a: 8'h00, c: 8'h00});
`endif
    send_repeat();
    chk("rpt_cmd_hold", cmd, 8'h18);
    chk("rpt_addr_hold", addr, 8'h00);
    send_frame(8'h10, 8'hEF, 8'h44, 8'hBB, 900, 450);
    lvl(1'b0, 900);
    lvl(1'b1, 450);
    for (int i = 0; i < 20; i++) begin
      lvl(1'b0, 56);
      lvl(1'b1, i[0] ? 169 : 56);
    end
    lvl(1'b0, 20);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_addr", addr, 0);
    chk("midrst_cmd", cmd, 0);
    chk("midrst_strobes", {data_valid, frame_err, rpt}, 0);
    m_addr = 8'h00;
    m_cmd  = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lvl(1'b0, 30);
    lvl(1'b1, 300);
    send_repeat();
    chk("post_rst_addr", addr, m_addr);
    chk("post_rst_cmd", cmd, m_cmd);
    send_frame(8'h33, 8'hCC, 8'h07, 8'hF8, 900, 450);
    lvl(1'b1, 100);
    chk("sb_empty", q.size(), 0);
    chk("final_addr", addr, m_addr);
    chk("final_cmd", cmd, m_cmd);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
